// File: rtl/vga_pkg.sv
// Shared definitions for the rectangle-fill engine: default frame geometry,
// field widths, control register offsets, CTRL bit positions and FSM states.
package vga_pkg;

  localparam int unsigned H_RES_DEF    = 640;
  localparam int unsigned V_RES_DEF    = 480;
  localparam int unsigned RAM_SIZE_DEF = 307200;

  localparam int unsigned XW = 10;   // X0 / W field width
  localparam int unsigned YW = 9;    // Y0 / H field width
  localparam int unsigned AW = 19;   // frame-buffer word address width
  localparam int unsigned DW = 16;   // register / pixel data width

  localparam logic [2:0] REG_X0    = 3'd0;
  localparam logic [2:0] REG_Y0    = 3'd1;
  localparam logic [2:0] REG_W     = 3'd2;
  localparam logic [2:0] REG_H     = 3'd3;
  localparam logic [2:0] REG_COLOR = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_DONE_CLR = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/vga_rect_addr_gen.sv
// Rectangle clipping and frame-buffer address stepping.
//   clk, rst : clock, synchronous active-high reset
//   x0,y0,w,h: requested rectangle (control register values)
//   load     : accepted START of a non-empty rectangle; latches clipped size
//   step     : a pixel write was accepted this cycle
//   empty    : requested rectangle clips to nothing (combinational)
//   last     : the pixel currently presented is the final one
//   addr     : word address of the pixel currently presented
module vga_rect_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_RES    = H_RES_DEF,
  parameter int unsigned V_RES    = V_RES_DEF,
  parameter int unsigned RAM_SIZE = RAM_SIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic          load,
  input  logic          step,
  output logic          empty,
  output logic          last,
  output logic [AW-1:0] addr
);

  logic [31:0]   x_room;
  logic [31:0]   y_room;
  logic [XW-1:0] weff_d;
  logic [YW-1:0] heff_d;
  logic [AW-1:0] base;

  logic [XW-1:0] weff;
  logic [YW-1:0] heff;
  logic [XW-1:0] col;
  logic [YW-1:0] row;

  assign x_room = H_RES - 32'(x0);
  assign y_room = V_RES - 32'(y0);
  assign weff_d = (32'(w) < x_room) ? w : XW'(x_room);
  assign heff_d = (32'(h) < y_room) ? h : YW'(y_room);

  // Constant-coefficient product: reduces to shifts and adds, registered into addr.
  assign base = AW'(32'(y0) * H_RES + 32'(x0));

  assign empty = (32'(x0) >= H_RES) || (32'(y0) >= V_RES) ||
                 (w == '0) || (h == '0) || (32'(base) >= RAM_SIZE);

  assign last = (col == weff - 1'b1) && (row == heff - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      weff <= '0;
      heff <= '0;
      col  <= '0;
      row  <= '0;
    end else if (load) begin
      addr <= base;
      weff <= weff_d;
      heff <= heff_d;
      col  <= '0;
      row  <= '0;
    end else if (step) begin
      if (col == weff - 1'b1) begin
        // End of line: skip the unfilled remainder to the next line start.
        col  <= '0;
        row  <= row + 1'b1;
        addr <= addr + AW'(H_RES) - AW'(weff) + AW'(1);
      end else begin
        col  <= col + 1'b1;
        addr <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Avalon-MM rectangle fill engine: control slave holds X0/Y0/W/H/COLOR/CTRL,
// master writes COLOR into every word of the clipped rectangle.
//   avs_s1_*  : control slave (clock, reset, 3-bit address, read latency 1)
//   avm_m1_*  : frame-buffer write master (address, write, data, waitrequest)
//   ins_irq_oIRQ : level interrupt, DONE and IRQ_EN
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int unsigned H_RES    = H_RES_DEF,
  parameter int unsigned V_RES    = V_RES_DEF,
  parameter int unsigned RAM_SIZE = RAM_SIZE_DEF
) (
  input  logic          avs_s1_clk_iCLK,
  input  logic          avs_s1_reset_iRST,
  input  logic [2:0]    avs_s1_address_iADDR,
  input  logic          avs_s1_chipselect_iCS,
  input  logic          avs_s1_read_iRD,
  input  logic          avs_s1_write_iWR,
  input  logic [DW-1:0] avs_s1_writedata_iDATA,
  output logic [DW-1:0] avs_s1_readdata_oDATA,
  output logic [AW-1:0] avm_m1_address_oADDR,
  output logic          avm_m1_write_oWR,
  output logic [DW-1:0] avm_m1_writedata_oDATA,
  input  logic          avm_m1_waitrequest_iWAIT,
  output logic          ins_irq_oIRQ
);

  logic clk;
  logic rst;
  assign clk = avs_s1_clk_iCLK;
  assign rst = avs_s1_reset_iRST;

  state_t        state;
  state_t        state_nx;
  logic          busy;

  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW-1:0] w;
  logic [YW-1:0] h;
  logic [DW-1:0] color;
  logic [DW-1:0] fill_color;
  logic          irq_en;
  logic          done;

  logic          reg_wr;
  logic          ctrl_wr;
  logic          start_acc;
  logic          abort_req;
  logic          pix_acc;
  logic          fill_end;
  logic          fill_empty;
  logic          fill_last;

  assign reg_wr    = avs_s1_chipselect_iCS && avs_s1_write_iWR;
  assign ctrl_wr   = reg_wr && (avs_s1_address_iADDR == REG_CTRL);
  assign start_acc = ctrl_wr && avs_s1_writedata_iDATA[CTRL_START] && (state == ST_IDLE);
  assign abort_req = ctrl_wr && avs_s1_writedata_iDATA[CTRL_ABORT] && (state == ST_RUN);
  assign pix_acc   = (state == ST_RUN) && !avm_m1_waitrequest_iWAIT;
  assign fill_end  = abort_req || (pix_acc && fill_last);

  vga_rect_addr_gen #(
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .RAM_SIZE (RAM_SIZE)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .x0    (x0),
    .y0    (y0),
    .w     (w),
    .h     (h),
    .load  (start_acc && !fill_empty),
    .step  (pix_acc),
    .empty (fill_empty),
    .last  (fill_last),
    .addr  (avm_m1_address_oADDR)
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      ST_IDLE: if (start_acc && !fill_empty) state_nx = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (fill_end) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0         <= '0;
      y0         <= '0;
      w          <= '0;
      h          <= '0;
      color      <= '0;
      fill_color <= '0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (reg_wr && (state == ST_IDLE)) begin
        case (avs_s1_address_iADDR)
          REG_X0:    x0    <= avs_s1_writedata_iDATA[XW-1:0];
          REG_Y0:    y0    <= avs_s1_writedata_iDATA[YW-1:0];
          REG_W:     w     <= avs_s1_writedata_iDATA[XW-1:0];
          REG_H:     h     <= avs_s1_writedata_iDATA[YW-1:0];
          REG_COLOR: color <= avs_s1_writedata_iDATA;
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en <= avs_s1_writedata_iDATA[CTRL_IRQ_EN];
      if (start_acc) fill_color <= color;
      // Setting DONE wins over clearing it in the same cycle; an empty START
      // both clears and sets, so it ends with DONE high.
      if (fill_end || (start_acc && fill_empty))
        done <= 1'b1;
      else if (start_acc || (ctrl_wr && avs_s1_writedata_iDATA[CTRL_DONE_CLR]))
        done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avs_s1_readdata_oDATA <= '0;
    end else if (avs_s1_chipselect_iCS && avs_s1_read_iRD) begin
      case (avs_s1_address_iADDR)
        REG_X0:    avs_s1_readdata_oDATA <= DW'(x0);
        REG_Y0:    avs_s1_readdata_oDATA <= DW'(y0);
        REG_W:     avs_s1_readdata_oDATA <= DW'(w);
        REG_H:     avs_s1_readdata_oDATA <= DW'(h);
        REG_COLOR: avs_s1_readdata_oDATA <= color;
        REG_CTRL:  avs_s1_readdata_oDATA <= {13'b0, irq_en, done, busy};
        default:   avs_s1_readdata_oDATA <= '0;
      endcase
    end else begin
      avs_s1_readdata_oDATA <= '0;
    end
  end

  assign avm_m1_write_oWR       = busy;
  assign avm_m1_writedata_oDATA = fill_color;
  assign ins_irq_oIRQ           = done && irq_en;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: a queue of expected pixels built
// from the clipping rules, checked every cycle the master writes.
module tb_vga_rect_fill;

  localparam int unsigned HR = 640;
  localparam int unsigned VR = 480;
  localparam int unsigned RS = 307200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  s_addr = '0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] s_wdata = '0;
  logic [15:0] s_rdata;
  logic [18:0] m_addr;
  logic        m_wr;
  logic [15:0] m_wdata;
  logic        stall = 1'b0;
  logic        irq;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned addr;
    logic [15:0] color;
  } pix_t;

  pix_t        exp_q[$];
  int unsigned acc_log[$];
  int unsigned acc_cyc[$];
  logic        stalled = 1'b0;
  logic        allow_drop = 1'b0;
  logic [18:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  int unsigned exp_basic [6] = '{1290, 1291, 1292, 1930, 1931, 1932};
  int unsigned stall_ofs [4] = '{0, 4, 5, 6};

  vga_rect_fill #(
    .H_RES    (640),
    .V_RES    (480),
    .RAM_SIZE (307200)
  ) dut (
    .avs_s1_clk_iCLK          (clk),
    .avs_s1_reset_iRST        (rst),
    .avs_s1_address_iADDR     (s_addr),
    .avs_s1_chipselect_iCS    (cs),
    .avs_s1_read_iRD          (rd),
    .avs_s1_write_iWR         (wr),
    .avs_s1_writedata_iDATA   (s_wdata),
    .avs_s1_readdata_oDATA    (s_rdata),
    .avm_m1_address_oADDR     (m_addr),
    .avm_m1_write_oWR         (m_wr),
    .avm_m1_writedata_oDATA   (m_wdata),
    .avm_m1_waitrequest_iWAIT (stall),
    .ins_irq_oIRQ             (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected pixel stream for one START, from the clipping rules.
  task automatic model_start(input int unsigned x0, input int unsigned y0,
                             input int unsigned w, input int unsigned h,
                             input logic [15:0] c, output int unsigned n);
    int unsigned we;
    int unsigned he;
    n = 0;
    if (x0 >= HR || y0 >= VR || w == 0 || h == 0) return;
    we = (w < HR - x0) ? w : HR - x0;
    he = (h < VR - y0) ? h : VR - y0;
    for (int unsigned r = 0; r < he; r++) begin
      for (int unsigned k = 0; k < we; k++) begin
        pix_t p;
        p.addr  = (y0 + r) * HR + x0 + k;
        p.color = c;
        exp_q.push_back(p);
      end
    end
    n = we * he;
  endtask

  // Pixel checker: every write cycle must present the head of the queue.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else if (m_wr) begin
      chk("addr_in_range", (32'(m_addr) < RS) ? 32'd1 : 32'd0, 32'd1);
      if (stalled) begin
        chk("hold_addr", 32'(m_addr), 32'(prev_addr));
        chk("hold_data", 32'(m_wdata), 32'(prev_data));
      end
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_write: got write at addr %0d, expected no write", m_addr);
      end else begin
        chk("pix_addr", 32'(m_addr), exp_q[0].addr);
        chk("pix_color", 32'(m_wdata), 32'(exp_q[0].color));
        if (!stall) void'(exp_q.pop_front());
      end
      if (!stall) begin
        acc_log.push_back(32'(m_addr));
        acc_cyc.push_back(cyc);
      end
      stalled   = stall;
      prev_addr = m_addr;
      prev_data = m_wdata;
    end else begin
      if (stalled && !allow_drop) begin
        vectors++;
        miscompares++;
        $display("FAIL write_dropped: got write=0 while stalled, expected write=1");
      end
      stalled = 1'b0;
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; s_addr = a; s_wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    cs = 1'b1; rd = 1'b1; s_addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    d = s_rdata;
  endtask

  task automatic setup(input logic [15:0] x0, input logic [15:0] y0,
                       input logic [15:0] w, input logic [15:0] h, input logic [15:0] c);
    bus_write(3'd0, x0);
    bus_write(3'd1, y0);
    bus_write(3'd2, w);
    bus_write(3'd3, h);
    bus_write(3'd4, c);
  endtask

  task automatic wait_idle(input int unsigned budget);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!m_wr) seen = 1'b1;
    end
    chk("idle_within_budget", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    acc_cyc.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned base_cyc;
    logic [15:0] rv;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", 32'(m_wr), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_wdata", 32'(m_wdata), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_rdata", 32'(s_rdata), 0);
    rst = 1'b0;
    bus_read(3'd5, rv); chk("rst_ctrl", 32'(rv), 0);
    bus_read(3'd4, rv); chk("rst_color", 32'(rv), 0);
    bus_read(3'd2, rv); chk("rst_w", 32'(rv), 0);

    // Unmapped address reads 0, writes ignored
    bus_write(3'd6, 16'hFFFF);
    bus_read(3'd6, rv); chk("unmapped_read", 32'(rv), 0);

    // 3x2 fill at (10,2)
    setup(16'd10, 16'd2, 16'd3, 16'd2, 16'hF800);
    bus_read(3'd1, rv); chk("readback_y0", 32'(rv), 2);
    model_start(10, 2, 3, 2, 16'hF800, n);
    chk("model_basic_n", n, 6);
    chk("model_basic_first", exp_q[0].addr, 1290);
    chk("model_basic_last", exp_q[5].addr, 1932);
    clear_logs();
    bus_write(3'd5, 16'h0001);
    base_cyc = cyc;
    wait_idle(20);
    chk("basic_count", acc_log.size(), 6);
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < acc_log.size()) begin
        chk("basic_addr", acc_log[i], exp_basic[i]);
        chk("basic_cycle", acc_cyc[i], base_cyc + i);
      end
    end
    bus_read(3'd5, rv); chk("basic_ctrl_done", 32'(rv), 32'h2);
    chk("basic_drained", exp_q.size(), 0);

    // Clipped at the bottom-right corner
    setup(16'd638, 16'd479, 16'd10, 16'd10, 16'h07FF);
    model_start(638, 479, 10, 10, 16'h07FF, n);
    chk("model_clip_n", n, 2);
    clear_logs();
    bus_write(3'd5, 16'h0001);
    wait_idle(20);
    chk("clip_count", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("clip_addr0", acc_log[0], 307198);
      chk("clip_addr1", acc_log[1], 307199);
    end
    bus_read(3'd5, rv); chk("clip_ctrl_done", 32'(rv), 32'h2);

    // Empty rectangles: W=0, then X0=640
    bus_write(3'd5, 16'h0008);
    chk("empty_pre_irq", 32'(irq), 0);
    setup(16'd10, 16'd2, 16'd0, 16'd5, 16'h1111);
    model_start(10, 2, 0, 5, 16'h1111, n);
    chk("model_empty_w_n", n, 0);
    clear_logs();
    bus_write(3'd5, 16'h0005);
    chk("empty_w_irq", 32'(irq), 1);
    chk("empty_w_nowrite", 32'(m_wr), 0);
    bus_read(3'd5, rv); chk("empty_w_ctrl", 32'(rv), 32'h6);
    chk("empty_w_count", acc_log.size(), 0);
    bus_write(3'd5, 16'h000C);
    chk("empty_w_irq_clr", 32'(irq), 0);
    setup(16'd640, 16'd0, 16'd5, 16'd5, 16'h2222);
    model_start(640, 0, 5, 5, 16'h2222, n);
    chk("model_empty_x_n", n, 0);
    bus_write(3'd5, 16'h0005);
    chk("empty_x_irq", 32'(irq), 1);
    chk("empty_x_nowrite", 32'(m_wr), 0);
    repeat (3) @(posedge clk);
    #1;
    bus_read(3'd5, rv); chk("empty_x_ctrl", 32'(rv), 32'h6);
    chk("empty_x_count", acc_log.size(), 0);
    bus_write(3'd5, 16'h0008);
    chk("empty_x_irq_off", 32'(irq), 0);

    // 4x1 fill with a 3-cycle stall on the second pixel
    setup(16'd100, 16'd7, 16'd4, 16'd1, 16'h07E0);
    model_start(100, 7, 4, 1, 16'h07E0, n);
    chk("model_stall_first", exp_q[0].addr, 4580);
    clear_logs();
    bus_write(3'd5, 16'h0001);
    base_cyc = cyc;
    @(posedge clk); #1;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stall = 1'b0;
    wait_idle(20);
    chk("stall_count", acc_log.size(), 4);
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < acc_cyc.size()) chk("stall_cycle", acc_cyc[i], base_cyc + stall_ofs[i]);
    end
    chk("stall_drained", exp_q.size(), 0);

    // ABORT after 5 accepted writes of a 100x100 fill, with waitrequest high
    setup(16'd0, 16'd0, 16'd100, 16'd100, 16'h001F);
    model_start(0, 0, 100, 100, 16'h001F, n);
    chk("model_abort_n", n, 10000);
    clear_logs();
    bus_write(3'd5, 16'h0005);
    repeat (5) @(posedge clk);
    #1;
    stall = 1'b1;
    allow_drop = 1'b1;
    bus_write(3'd5, 16'h0006);
    exp_q.delete();
    chk("abort_write_low", 32'(m_wr), 0);
    chk("abort_irq", 32'(irq), 1);
    chk("abort_count", acc_log.size(), 5);
    if (acc_log.size() == 5) chk("abort_last_addr", acc_log[4], 4);
    bus_read(3'd5, rv); chk("abort_ctrl", 32'(rv), 32'h6);
    bus_write(3'd5, 16'h000C);
    chk("abort_irq_clr", 32'(irq), 0);
    stall = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    allow_drop = 1'b0;
    chk("abort_no_more", acc_log.size(), 5);

    // START and COLOR/X0 writes while busy are ignored
    setup(16'd20, 16'd30, 16'd8, 16'd2, 16'hABCD);
    model_start(20, 30, 8, 2, 16'hABCD, n);
    chk("model_busy_first", exp_q[0].addr, 19220);
    clear_logs();
    bus_write(3'd5, 16'h0001);
    bus_write(3'd5, 16'h0001);
    bus_write(3'd4, 16'h1234);
    bus_write(3'd0, 16'd5);
    bus_read(3'd5, rv); chk("busy_ctrl", 32'(rv), 32'h1);
    wait_idle(40);
    chk("busy_count", acc_log.size(), 16);
    bus_read(3'd4, rv); chk("busy_color_kept", 32'(rv), 32'hABCD);
    bus_read(3'd0, rv); chk("busy_x0_kept", 32'(rv), 20);
    bus_read(3'd5, rv); chk("busy_ctrl_done", 32'(rv), 32'h2);

    // Reset asserted mid-fill
    setup(16'd5, 16'd5, 16'd10, 16'd10, 16'h0F0F);
    model_start(5, 5, 10, 10, 16'h0F0F, n);
    clear_logs();
    bus_write(3'd5, 16'h0001);
    repeat (2) @(posedge clk);
    #1;
    allow_drop = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("rstrun_write_low", 32'(m_wr), 0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    allow_drop = 1'b0;
    chk("rstrun_write_still_low", 32'(m_wr), 0);
    chk("rstrun_addr", 32'(m_addr), 0);
    chk("rstrun_wdata", 32'(m_wdata), 0);
    chk("rstrun_count", acc_log.size(), 2);
    bus_read(3'd5, rv); chk("rstrun_ctrl", 32'(rv), 0);
    bus_read(3'd0, rv); chk("rstrun_x0", 32'(rv), 0);

    chk("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
